// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// opcode/funct values, instruction classes and datapath select encodings.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Instruction classes: what the FSM needs to know beyond the ALU controls
  localparam logic [3:0] CL_RALU = 4'd0;
  localparam logic [3:0] CL_JR   = 4'd1;
  localparam logic [3:0] CL_IALU = 4'd2;
  localparam logic [3:0] CL_LW   = 4'd3;
  localparam logic [3:0] CL_SW   = 4'd4;
  localparam logic [3:0] CL_BEQ  = 4'd5;
  localparam logic [3:0] CL_J    = 4'd6;
  localparam logic [3:0] CL_JAL  = 4'd7;
  localparam logic [3:0] CL_ILL  = 4'd8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_LUI = 3'd7;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] SRCA_RD1   = 2'd0;
  localparam logic [1:0] SRCA_SHAMT = 2'd1;
  localparam logic [1:0] SRCA_LUI   = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational Op/Funct decoder: instruction class plus the ALU controls the
// FSM drives while an instruction is in EXE.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] iclass,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic       ext_op
);

  // Map opcode/funct to class and ALU controls; anything unlisted is illegal
  always_comb begin
    iclass    = CL_ILL;
    alu_op    = ALU_ADD;
    alu_src_a = SRCA_RD1;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = CL_RALU; alu_op = ALU_ADD; end
          FN_SUBU: begin iclass = CL_RALU; alu_op = ALU_SUB; end
          FN_AND:  begin iclass = CL_RALU; alu_op = ALU_AND; end
          FN_OR:   begin iclass = CL_RALU; alu_op = ALU_OR;  end
          FN_SLT:  begin iclass = CL_RALU; alu_op = ALU_SLT; end
          FN_SLL:  begin iclass = CL_RALU; alu_op = ALU_SLL; alu_src_a = SRCA_SHAMT; end
          FN_SRL:  begin iclass = CL_RALU; alu_op = ALU_SRL; alu_src_a = SRCA_SHAMT; end
          FN_JR:   begin iclass = CL_JR; end
          default: begin iclass = CL_ILL; end
        endcase
      end
      OP_ADDI: begin
        iclass = CL_IALU; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_ORI: begin
        iclass = CL_IALU; alu_op = ALU_OR; alu_src_b = 1'b1;
      end
      OP_LUI: begin
        iclass = CL_IALU; alu_op = ALU_LUI; alu_src_a = SRCA_LUI; alu_src_b = 1'b1;
      end
      OP_LW: begin
        iclass = CL_LW; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_SW: begin
        iclass = CL_SW; alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = 1'b1;
      end
      OP_BEQ:  begin iclass = CL_BEQ; alu_op = ALU_SUB; end
      OP_J:    begin iclass = CL_J;   end
      OP_JAL:  begin iclass = CL_JAL; end
      default: begin iclass = CL_ILL; end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXE/MEM/WB over a shared
// memory with a req/ready handshake, a wait timeout and a retire counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       NPCOp,
  output logic             RegWrite,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             EXTOp,
  output logic [1:0]       ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_r, state_nxt_s;
  logic [TW-1:0]    timer_r;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r, bus_err_r;
  logic             wait_s, timeout_s, set_illegal_s;
  logic             mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;
  logic             iord_s, ext_op_s, alu_src_b_s;
  logic [1:0]       npc_op_s, gpr_sel_s, wd_sel_s, alu_src_a_s;
  logic [2:0]       alu_op_s;

  logic [3:0]       iclass_s;
  logic [2:0]       dec_alu_op_s;
  logic [1:0]       dec_src_a_s;
  logic             dec_src_b_s, dec_ext_s;

  mc_decode u_decode (
    .op        (Op),
    .funct     (Funct),
    .iclass    (iclass_s),
    .alu_op    (dec_alu_op_s),
    .alu_src_a (dec_src_a_s),
    .alu_src_b (dec_src_b_s),
    .ext_op    (dec_ext_s)
  );

  // Next-state and per-state control outputs
  always_comb begin
    state_nxt_s   = state_r;
    wait_s        = 1'b0;
    timeout_s     = 1'b0;
    set_illegal_s = 1'b0;
    mem_req_s     = 1'b0;
    mem_write_s   = 1'b0;
    iord_s        = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    npc_op_s      = NPC_PC4;
    reg_write_s   = 1'b0;
    gpr_sel_s     = GPR_RD;
    wd_sel_s      = WD_ALU;
    ext_op_s      = 1'b0;
    alu_src_a_s   = SRCA_RD1;
    alu_src_b_s   = 1'b0;
    alu_op_s      = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = S_DECODE;
        end else begin
          wait_s = 1'b1;
          if (timer_r == TW'(TIMEOUT)) begin
            timeout_s   = 1'b1;
            state_nxt_s = S_HALT;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end
      end
      S_DECODE: begin
        case (iclass_s)
          CL_J: begin
            pc_write_s  = 1'b1;
            npc_op_s    = NPC_J;
            state_nxt_s = S_FETCH;
          end
          CL_JAL: begin
            pc_write_s  = 1'b1;
            npc_op_s    = NPC_J;
            reg_write_s = 1'b1;
            gpr_sel_s   = GPR_RA;
            wd_sel_s    = WD_PC;
            state_nxt_s = S_FETCH;
          end
          CL_ILL: begin
            set_illegal_s = 1'b1;
            state_nxt_s   = S_FETCH;
          end
          default: state_nxt_s = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass_s)
          CL_JR: begin
            pc_write_s  = 1'b1;
            npc_op_s    = NPC_JR;
            state_nxt_s = S_FETCH;
          end
          CL_BEQ: begin
            alu_op_s    = dec_alu_op_s;
            pc_write_s  = Zero;
            npc_op_s    = NPC_BR;
            state_nxt_s = S_FETCH;
          end
          CL_LW, CL_SW, CL_RALU, CL_IALU: begin
            alu_op_s    = dec_alu_op_s;
            alu_src_a_s = dec_src_a_s;
            alu_src_b_s = dec_src_b_s;
            ext_op_s    = dec_ext_s;
            if ((iclass_s == CL_LW) || (iclass_s == CL_SW)) begin
              state_nxt_s = S_MEM;
            end else begin
              state_nxt_s = S_WB;
            end
          end
          default: state_nxt_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req_s   = 1'b1;
        iord_s      = 1'b1;
        mem_write_s = (iclass_s == CL_SW);
        if (mem_ready) begin
          if (iclass_s == CL_SW) begin
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_WB;
          end
        end else begin
          wait_s = 1'b1;
          if (timer_r == TW'(TIMEOUT)) begin
            timeout_s   = 1'b1;
            state_nxt_s = S_HALT;
          end else begin
            state_nxt_s = S_MEM;
          end
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        if (iclass_s == CL_LW) begin
          wd_sel_s  = WD_MDR;
          gpr_sel_s = GPR_RT;
        end else if (iclass_s == CL_IALU) begin
          gpr_sel_s = GPR_RT;
        end else begin
          gpr_sel_s = GPR_RD;
        end
        state_nxt_s = S_FETCH;
      end
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // State, wait timer, sticky status flags and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_FETCH;
      timer_r   <= {TW{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s == state_r) && wait_s) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= {TW{1'b0}};
      end
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | timeout_s;
      if ((state_nxt_s == S_FETCH) && (state_r != S_FETCH)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Strobes are qualified by reset so nothing fires while it is held low
  assign mem_req   = mem_req_s   & rst;
  assign MemWrite  = mem_write_s & rst;
  assign IRWrite   = ir_write_s  & rst;
  assign PCWrite   = pc_write_s  & rst;
  assign RegWrite  = reg_write_s & rst;
  assign IorD      = iord_s;
  assign NPCOp     = npc_op_s;
  assign GPRSel    = gpr_sel_s;
  assign WDSel     = wd_sel_s;
  assign EXTOp     = ext_op_s;
  assign ALUSrcA   = alu_src_a_s;
  assign ALUSrcB   = alu_src_b_s;
  assign ALUOp     = alu_op_s;
  assign illegal   = illegal_r;
  assign bus_err   = bus_err_r;
  assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control outputs.
module tb_mc_ctrl;

  localparam int TO = 6;
  localparam int CW = 4;

  localparam logic [3:0] K_RALU = 4'd0, K_JR = 4'd1, K_IALU = 4'd2, K_LW = 4'd3,
                         K_SW = 4'd4, K_BEQ = 4'd5, K_J = 4'd6, K_JAL = 4'd7,
                         K_ILL = 4'd8;

  typedef struct packed {
    logic       req, mw, iord, irw, pcw;
    logic [1:0] npc;
    logic       rw;
    logic [1:0] gpr, wd;
    logic       ext;
    logic [1:0] sa;
    logic       sb;
    logic [2:0] aop;
  } ov_t;

  typedef struct packed {
    logic       rdy;
    logic [2:0] ph;
    ov_t        e;
  } row_t;

  typedef struct packed {
    logic [5:0] op, fn;
    logic [3:0] cls;
    logic [2:0] aop;
    logic [1:0] sa;
    logic       sb, ext;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] Op, Funct;
  logic Zero, mem_ready;
  logic mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrcB;
  logic [1:0] NPCOp, GPRSel, WDSel, ALUSrcA;
  logic [2:0] ALUOp;
  logic illegal, bus_err;
  logic [CW-1:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m = 0;
  logic ill_m = 1'b0;
  logic bus_m = 1'b0;
  row_t q[$];
  ov_t dut_ov;

  always #5 clk = ~clk;

  assign dut_ov = {mem_req, MemWrite, IorD, IRWrite, PCWrite, NPCOp, RegWrite,
                   GPRSel, WDSel, EXTOp, ALUSrcA, ALUSrcB, ALUOp};

  mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite),
    .GPRSel(GPRSel), .WDSel(WDSel), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .bus_err(bus_err),
    .instr_cnt(instr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t entry(int k);
    ent_t e;
    e = '0;
    e.fn = 6'($urandom);
    case (k)
      0:  begin e.op = 6'h00; e.fn = 6'h21; e.cls = K_RALU; e.aop = 3'd0; end
      1:  begin e.op = 6'h00; e.fn = 6'h23; e.cls = K_RALU; e.aop = 3'd1; end
      2:  begin e.op = 6'h00; e.fn = 6'h24; e.cls = K_RALU; e.aop = 3'd2; end
      3:  begin e.op = 6'h00; e.fn = 6'h25; e.cls = K_RALU; e.aop = 3'd3; end
      4:  begin e.op = 6'h00; e.fn = 6'h2A; e.cls = K_RALU; e.aop = 3'd4; end
      5:  begin e.op = 6'h00; e.fn = 6'h00; e.cls = K_RALU; e.aop = 3'd5; e.sa = 2'd1; end
      6:  begin e.op = 6'h00; e.fn = 6'h02; e.cls = K_RALU; e.aop = 3'd6; e.sa = 2'd1; end
      7:  begin e.op = 6'h00; e.fn = 6'h08; e.cls = K_JR; end
      8:  begin e.op = 6'h08; e.cls = K_IALU; e.aop = 3'd0; e.sb = 1'b1; e.ext = 1'b1; end
      9:  begin e.op = 6'h0D; e.cls = K_IALU; e.aop = 3'd3; e.sb = 1'b1; end
      10: begin e.op = 6'h0F; e.cls = K_IALU; e.aop = 3'd7; e.sa = 2'd2; e.sb = 1'b1; end
      11: begin e.op = 6'h23; e.cls = K_LW; e.aop = 3'd0; e.sb = 1'b1; e.ext = 1'b1; end
      12: begin e.op = 6'h2B; e.cls = K_SW; e.aop = 3'd0; e.sb = 1'b1; e.ext = 1'b1; end
      13: begin e.op = 6'h04; e.cls = K_BEQ; e.aop = 3'd1; end
      14: begin e.op = 6'h02; e.cls = K_J; end
      15: begin e.op = 6'h03; e.cls = K_JAL; end
      16: begin e.op = 6'h3F; e.cls = K_ILL; end
      17: begin e.op = 6'h00; e.fn = 6'h3F; e.cls = K_ILL; end
      default: begin e.op = 6'h01; e.cls = K_ILL; end
    endcase
    return e;
  endfunction

  // Expected cycles of a memory phase; returns 1 when the access times out
  function automatic logic push_mem(int w, logic [2:0] ph, logic iord, logic mw);
    row_t r;
    int n;
    n = (w > TO) ? TO + 1 : w;
    for (int i = 0; i < n; i++) begin
      r = '0; r.ph = ph; r.e.req = 1'b1; r.e.iord = iord; r.e.mw = mw;
      q.push_back(r);
    end
    if (w > TO) begin
      for (int i = 0; i < 3; i++) begin
        r = '0; r.ph = 3'd5; r.rdy = (i != 1);
        q.push_back(r);
      end
      return 1'b1;
    end
    r = '0; r.ph = ph; r.rdy = 1'b1; r.e.req = 1'b1; r.e.iord = iord; r.e.mw = mw;
    r.e.irw = (ph == 3'd0); r.e.pcw = (ph == 3'd0);
    q.push_back(r);
    return 1'b0;
  endfunction

  function automatic logic build(ent_t e, int fw, int mw, logic z);
    row_t r;
    if (push_mem(fw, 3'd0, 1'b0, 1'b0)) return 1'b1;
    r = '0; r.ph = 3'd1; r.rdy = 1'($urandom);
    if (e.cls == K_J || e.cls == K_JAL) begin
      r.e.pcw = 1'b1; r.e.npc = 2'd2;
      if (e.cls == K_JAL) begin r.e.rw = 1'b1; r.e.gpr = 2'd2; r.e.wd = 2'd2; end
      q.push_back(r);
      return 1'b0;
    end
    q.push_back(r);
    if (e.cls == K_ILL) return 1'b0;
    r = '0; r.ph = 3'd2; r.rdy = 1'($urandom);
    case (e.cls)
      K_BEQ:   begin r.e.pcw = z; r.e.npc = 2'd1; r.e.aop = 3'd1; end
      K_JR:    begin r.e.pcw = 1'b1; r.e.npc = 2'd3; end
      default: begin r.e.aop = e.aop; r.e.sa = e.sa; r.e.sb = e.sb; r.e.ext = e.ext; end
    endcase
    q.push_back(r);
    if (e.cls == K_LW || e.cls == K_SW) begin
      if (push_mem(mw, 3'd3, 1'b1, e.cls == K_SW)) return 1'b1;
    end
    if (e.cls == K_LW || e.cls == K_RALU || e.cls == K_IALU) begin
      r = '0; r.ph = 3'd4; r.rdy = 1'($urandom); r.e.rw = 1'b1;
      r.e.gpr = (e.cls == K_RALU) ? 2'd0 : 2'd1;
      r.e.wd  = (e.cls == K_LW) ? 2'd1 : 2'd0;
      q.push_back(r);
    end
    return 1'b0;
  endfunction

  task automatic run_rows(input int n);
    row_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      mem_ready = r.rdy;
      @(negedge clk);
      check_eq($sformatf("outs_ph%0d", r.ph), 32'(dut_ov), 32'(r.e));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input int k, input int fw, input int mw, input logic z);
    ent_t e;
    logic halted;
    e = entry(k);
    Op = e.op; Funct = e.fn; Zero = z;
    halted = build(e, fw, mw, z);
    run_rows(64);
    if (halted) bus_m = 1'b1;
    else cnt_m++;
    if (!halted && e.cls == K_ILL) ill_m = 1'b1;
    check_eq("instr_cnt", 32'(instr_cnt), 32'(cnt_m % (1 << CW)));
    check_eq("illegal", 32'(illegal), 32'(ill_m));
    check_eq("bus_err", 32'(bus_err), 32'(bus_m));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("rst_strobes", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
    check_eq("rst_cnt", 32'(instr_cnt), 32'd0);
    check_eq("rst_flags", 32'({illegal, bus_err}), 32'd0);
    cnt_m = 0; ill_m = 1'b0; bus_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? TO : (r % 4);
  endfunction

  initial begin
    ent_t e;
    logic h;
    rst = 1'b1; Op = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
    #1;
    do_reset();
    // directed: lw, beq taken/not taken, jal, sw with waits, illegal then addu
    do_instr(11, 0, 0, 1'b0);
    do_instr(13, 0, 0, 1'b1);
    do_instr(13, 0, 0, 1'b0);
    do_instr(15, 0, 0, 1'b0);
    do_instr(12, 0, 3, 1'b0);
    do_instr(16, 0, 0, 1'b0);
    do_instr(0, 0, 0, 1'b0);
    do_instr(11, TO, TO, 1'b1);
    for (int i = 0; i < 60; i++) begin
      do_instr($urandom_range(0, 18), pick_wait(), pick_wait(), 1'($urandom));
    end
    // reset in the middle of an R-type write-back
    e = entry(0);
    Op = e.op; Funct = e.fn; Zero = 1'b0;
    h = build(e, 0, 0, 1'b0);
    run_rows(3);
    q.delete();
    mem_ready = 1'b0;
    #2;
    check_eq("wb_before_rst", 32'(RegWrite), 32'd1);
    do_reset();
    do_instr(9, 1, 0, 1'b0);
    // timeout in FETCH, then in MEM of a lw
    do_instr(3, TO + 1, 0, 1'b0);
    do_reset();
    do_instr(11, 0, TO + 1, 1'b0);
    do_reset();
    do_instr(14, 2, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
